// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline memory stage (CPU) and a debug/loader port (DBG).
// CPU has fixed priority; DBG uses idle slots, forced slots after starvation, or a halt handshake.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  logic          clk,
    input  logic          srst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          dbg_halt_req,
    output logic          dbg_halt_ack,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] ARB_CPU  = 2'd0;
    localparam logic [1:0] DBG_SLOT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] STARVE_SAT  = CNT_W'(STARVE_MAX);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             r_dbg_rvalid;
    logic [DW-1:0]    r_dbg_rdata;

    logic             w_dbg_gnt;
    logic             w_cpu_stall;
    logic             w_dbg_denied;
    logic             w_starve_hit;
    logic             w_cpu_we;

    // Grant/stall decode: DBG_SLOT and HALT both hand the memory to DBG unconditionally.
    always_comb begin
        w_dbg_gnt   = 1'b0;
        w_cpu_stall = 1'b0;
        case (r_state)
            DBG_SLOT, HALT: begin
                w_dbg_gnt   = dbg_req;
                w_cpu_stall = cpu_req;
            end
            default: begin
                w_dbg_gnt   = ~cpu_req & dbg_req;
                w_cpu_stall = 1'b0;
            end
        endcase
    end

    assign w_dbg_denied = dbg_req & ~w_dbg_gnt;
    assign w_starve_hit = w_dbg_denied & (r_starve_cnt == STARVE_LAST);

    // A halt request outranks a pending forced slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_CPU: begin
                if (dbg_halt_req)
                    w_state_nxt = HALT;
                else if (w_starve_hit)
                    w_state_nxt = DBG_SLOT;
                else
                    w_state_nxt = ARB_CPU;
            end
            DBG_SLOT: w_state_nxt = dbg_halt_req ? HALT : ARB_CPU;
            HALT:     w_state_nxt = dbg_halt_req ? HALT : ARB_CPU;
            default:  w_state_nxt = ARB_CPU;
        endcase
    end

    always_comb begin
        if (!dbg_req || w_dbg_gnt)
            w_starve_nxt = '0;
        else if (r_starve_cnt != STARVE_SAT)
            w_starve_nxt = r_starve_cnt + 1'b1;
        else
            w_starve_nxt = r_starve_cnt;
    end

    // A stalled or idle CPU must never write; the CPU drives the bus whenever DBG is not granted.
    assign w_cpu_we = cpu_req & cpu_we & ~w_cpu_stall;

    assign mem_we    = w_dbg_gnt ? dbg_we    : w_cpu_we;
    assign mem_addr  = w_dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = w_dbg_gnt ? dbg_wdata : cpu_wdata;

    assign cpu_rdata    = mem_rdata;
    assign cpu_stall    = w_cpu_stall;
    assign dbg_gnt      = w_dbg_gnt;
    assign dbg_rvalid   = r_dbg_rvalid;
    assign dbg_rdata    = r_dbg_rdata;
    assign dbg_halt_ack = (r_state == HALT);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ARB_CPU;
            r_starve_cnt <= '0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
            if (w_dbg_gnt && !dbg_we)
                r_dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        srst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_halt_req, dbg_halt_ack;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tb_mem [0:255];

    int n_checks = 0;
    int n_err    = 0;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(8), .CNT_W(4)) dut (
        .clk(clk), .srst(srst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_halt_req(dbg_halt_req), .dbg_halt_ack(dbg_halt_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_halt_req = 0;
        @(negedge clk); @(negedge clk);
        srst = 1'b0;
        #1;
        check("rst_ack",    {31'b0, dbg_halt_ack}, 32'd0);
        check("rst_rvalid", {31'b0, dbg_rvalid},   32'd0);
        check("rst_rdata",  dbg_rdata,             32'd0);
        check("rst_stall",  {31'b0, cpu_stall},    32'd0);
        check("rst_gnt",    {31'b0, dbg_gnt},      32'd0);
        check("rst_we",     {31'b0, mem_we},       32'd0);

        // CPU store then load
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        check("st_we",    {31'b0, mem_we},    32'd1);
        check("st_addr",  mem_addr,           32'h10);
        check("st_stall", {31'b0, cpu_stall}, 32'd0);
        check("st_gnt",   {31'b0, dbg_gnt},   32'd0);
        @(negedge clk);
        cpu_we = 0;
        #1;
        check("ld_rdata", cpu_rdata,          32'hDEADBEEF);
        check("ld_we",    {31'b0, mem_we},    32'd0);
        check("ld_stall", {31'b0, cpu_stall}, 32'd0);
        check("ld_gnt",   {31'b0, dbg_gnt},   32'd0);

        // Idle steal: preload 0x20 through the CPU, then DBG reads it in an idle cycle
        @(negedge clk);
        cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
        @(negedge clk);
        cpu_req = 0; cpu_we = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        #1;
        check("steal_gnt",   {31'b0, dbg_gnt},   32'd1);
        check("steal_stall", {31'b0, cpu_stall}, 32'd0);
        check("steal_addr",  mem_addr,           32'h20);
        check("steal_we",    {31'b0, mem_we},    32'd0);
        @(negedge clk);
        dbg_req = 0;
        #1;
        check("steal_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        check("steal_rdata",  dbg_rdata,           32'h12345678);
        @(negedge clk);
        #1;
        check("rvalid_drop", {31'b0, dbg_rvalid}, 32'd0);
        check("rdata_hold",  dbg_rdata,           32'h12345678);

        // Starvation: both requesting, forced slot on cycle 8, then again on cycle 17
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("starve_gnt",   {31'b0, dbg_gnt},   32'd0);
            check("starve_stall", {31'b0, cpu_stall}, 32'd0);
            @(negedge clk);
        end
        #1;
        check("slot_gnt",   {31'b0, dbg_gnt},   32'd1);
        check("slot_stall", {31'b0, cpu_stall}, 32'd1);
        check("slot_addr",  mem_addr,           32'h20);
        @(negedge clk);
        #1;
        check("post_slot_gnt",    {31'b0, dbg_gnt},    32'd0);
        check("post_slot_stall",  {31'b0, cpu_stall},  32'd0);
        check("post_slot_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        check("post_slot_rdata",  cpu_rdata,           32'hDEADBEEF);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            check("restart_gnt", {31'b0, dbg_gnt}, 32'd0);
        end
        @(negedge clk);
        #1;
        check("slot2_gnt",   {31'b0, dbg_gnt},   32'd1);
        check("slot2_stall", {31'b0, cpu_stall}, 32'd1);
        @(negedge clk);
        cpu_req = 0; dbg_req = 0;

        // Halt while the CPU streams stores
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h0000000A;
        dbg_halt_req = 1;
        #1;
        check("hreq_we",    {31'b0, mem_we},       32'd1);
        check("hreq_stall", {31'b0, cpu_stall},    32'd0);
        check("hreq_ack",   {31'b0, dbg_halt_ack}, 32'd0);
        @(negedge clk);
        cpu_addr = 32'h44; cpu_wdata = 32'h0000000B;
        #1;
        check("halt_ack",   {31'b0, dbg_halt_ack}, 32'd1);
        check("halt_stall", {31'b0, cpu_stall},    32'd1);
        check("halt_we",    {31'b0, mem_we},       32'd0);
        check("halt_gnt",   {31'b0, dbg_gnt},      32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80 + 32'(4 * k); dbg_wdata = 32'(k + 1);
            #1;
            check("hwr_gnt",   {31'b0, dbg_gnt},   32'd1);
            check("hwr_we",    {31'b0, mem_we},    32'd1);
            check("hwr_addr",  mem_addr,           32'h80 + 32'(4 * k));
            check("hwr_wdata", mem_wdata,          32'(k + 1));
            check("hwr_stall", {31'b0, cpu_stall}, 32'd1);
        end
        @(negedge clk);
        dbg_req = 0; dbg_we = 0; dbg_halt_req = 0;
        #1;
        check("hrel_ack",   {31'b0, dbg_halt_ack}, 32'd1);
        check("hrel_stall", {31'b0, cpu_stall},    32'd1);
        check("hrel_we",    {31'b0, mem_we},       32'd0);
        @(negedge clk);
        #1;
        check("resume_ack",   {31'b0, dbg_halt_ack}, 32'd0);
        check("resume_stall", {31'b0, cpu_stall},    32'd0);
        check("resume_we",    {31'b0, mem_we},       32'd1);
        check("resume_addr",  mem_addr,              32'h44);
        @(negedge clk);
        cpu_req = 0; cpu_we = 0;
        check("mem_80", tb_mem[8'h20], 32'd1);
        check("mem_84", tb_mem[8'h21], 32'd2);
        check("mem_88", tb_mem[8'h22], 32'd3);
        check("mem_40", tb_mem[8'h10], 32'h0000000A);
        check("mem_44", tb_mem[8'h11], 32'h0000000B);

        // Halt request in the cycle the counter reaches STARVE_MAX-1 wins over the forced slot
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) dbg_halt_req = 1;
            #1;
            check("hp_gnt", {31'b0, dbg_gnt}, 32'd0);
            @(negedge clk);
        end
        #1;
        check("hp_ack",   {31'b0, dbg_halt_ack}, 32'd1);
        check("hp_stall", {31'b0, cpu_stall},    32'd1);
        check("hp_gnt2",  {31'b0, dbg_gnt},      32'd1);

        // Reset mid-HALT with a granted DBG read in flight
        srst = 1;
        @(negedge clk);
        srst = 0; dbg_halt_req = 0;
        #1;
        check("mrst_ack",    {31'b0, dbg_halt_ack}, 32'd0);
        check("mrst_rvalid", {31'b0, dbg_rvalid},   32'd0);
        check("mrst_rdata",  dbg_rdata,             32'd0);
        check("mrst_stall",  {31'b0, cpu_stall},    32'd0);
        check("mrst_gnt",    {31'b0, dbg_gnt},      32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline memory stage (CPU port) and a debug/loader port (DBG port).
- The CPU has fixed priority. DBG takes idle slots, takes forced slots after a starvation limit, or takes exclusive ownership through a halt handshake.
- Drives cpu_stall so the pipeline holds its memory-stage registers while DBG owns the memory.
- The memory has a combinational read and a write on the clock edge; the arbiter issues one access per cycle.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 8, number of consecutive denied DBG request cycles before a forced DBG slot (must be ≥1)
- CNT_W, 4, starvation counter width (must satisfy 2^CNT_W > STARVE_MAX)

Ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- cpu_req  in  1  memory-stage access valid (load or store)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  CPU read data, combinational from mem_rdata
- cpu_stall  out  1  hold pipeline; CPU access not performed this cycle
- dbg_req  in  1  DBG access request, held until dbg_gnt
- dbg_we  in  1  DBG write enable
- dbg_addr  in  AW  DBG address
- dbg_wdata  in  DW  DBG write data
- dbg_gnt  out  1  DBG access performed this cycle
- dbg_rvalid  out  1  registered, one cycle after a granted DBG read
- dbg_rdata  out  DW  registered DBG read data
- dbg_halt_req  in  1  request exclusive memory ownership
- dbg_halt_ack  out  1  exclusive ownership active
- mem_we  out  1  write enable to the data memory
- mem_addr  out  AW  address to the data memory
- mem_wdata  out  DW  write data to the data memory
- mem_rdata  in  DW  combinational read data from the data memory

Behaviour:
- Interface: one clock, clk; reset srst is synchronous and active-high.
- State machine states: ARB_CPU, DBG_SLOT, HALT. The state is registered; grant and stall decode combinationally from the state and the current requests.
- ARB_CPU:
  - cpu_req=1: CPU owns the memory, dbg_gnt=0, cpu_stall=0.
  - cpu_req=0 and dbg_req=1: DBG owns the memory (idle-slot steal), dbg_gnt=1.
- DBG_SLOT:
  - DBG owns the memory for exactly one cycle; dbg_gnt=dbg_req; cpu_stall=cpu_req.
  - Next state is HALT if dbg_halt_req=1, otherwise ARB_CPU.
- HALT:
  - DBG owns the memory every cycle; dbg_gnt=dbg_req; cpu_stall=cpu_req; dbg_halt_ack=1.
  - Leave to ARB_CPU on the first cycle with dbg_halt_req=0. dbg_halt_ack drops in that same next cycle.
- Transitions from ARB_CPU:
  - dbg_halt_req=1 → HALT on the next edge (priority over starvation).
  - Otherwise, starve_cnt==STARVE_MAX-1 and a denied DBG request this cycle → DBG_SLOT.
- starve_cnt:
  - Increments on each cycle with dbg_req=1 and dbg_gnt=0.
  - Clears on any dbg_gnt, and on dbg_req=0.
  - Saturates at STARVE_MAX.
- Memory mux:
  - mem_we = owner_we & owner_req. A stalled or absent requester never writes.
  - mem_addr and mem_wdata come from the owner; with no requester they come from the CPU.
- cpu_rdata = mem_rdata every cycle. It is valid only when cpu_stall=0.
- DBG read return:
  - On a granted DBG read, dbg_rdata <= mem_rdata and dbg_rvalid <= 1 at the next edge.
  - Otherwise dbg_rvalid <= 0 and dbg_rdata holds its value.
- Simultaneous requests: exactly one memory access per cycle. There is never a same-cycle CPU/DBG write conflict.
- Reset values (srst, including mid-operation): state ARB_CPU, starve_cnt 0, dbg_rvalid 0, dbg_rdata 0, dbg_halt_ack 0. After reset, cpu_stall and dbg_gnt follow the ARB_CPU decode. An in-flight dbg_rvalid is discarded.

Test Plan:
- CPU store then load: cpu_req/we to address 0x10, data 0xDEADBEEF, then a read of 0x10 → mem_we=1 in the first cycle, cpu_rdata=0xDEADBEEF in the second, cpu_stall=0 throughout, dbg_gnt=0.
- Idle steal: cpu_req=0, DBG read of 0x20 holding 0x12345678 → dbg_gnt=1 the same cycle; dbg_rvalid=1 with dbg_rdata=0x12345678 the next cycle.
- Starvation (STARVE_MAX=8): cpu_req and dbg_req both held high → dbg_gnt=0 for cycles 0–7; cycle 8 is DBG_SLOT with dbg_gnt=1 and cpu_stall=1; cycle 9 is CPU with cpu_stall=0; the counter restarts.
- Halt: dbg_halt_req=1 while the CPU streams stores → the next cycle has dbg_halt_ack=1 and cpu_stall=1 with no CPU write reaching memory. DBG performs 3 writes. Deasserting dbg_halt_req → cpu_stall=0 and dbg_halt_ack=0 the next cycle.
- Halt priority: dbg_halt_req asserted in the same cycle starve_cnt reaches 7 → next state is HALT, not DBG_SLOT.
- Reset mid-operation: srst pulsed during HALT with a DBG read granted → next cycle dbg_halt_ack=0, dbg_rvalid=0, dbg_rdata=0, state ARB_CPU, cpu_stall=0 with cpu_req=1.
